// File: rtl/reg_scoreboard_if.sv
// Decode-side handshake bundle for the register scoreboard: issue, load-return,
// write-back and source-operand inputs plus the hazard/forwarding outputs.
interface reg_scoreboard_if;
  logic       issue_fire;
  logic       issue_we;
  logic       issue_is_load;
  logic [4:0] issue_dest;
  logic       ld_done;
  logic [4:0] ld_done_dest;
  logic       retire;
  logic [4:0] retire_dest;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use1;
  logic       use2;
  logic       ds_valid;
  logic       stall;
  logic       busy1;
  logic       busy2;
  logic       sb_full;
  logic       err;

  modport master (
    output issue_fire, issue_we, issue_is_load, issue_dest,
    output ld_done, ld_done_dest, retire, retire_dest,
    output rs1, rs2, use1, use2, ds_valid,
    input  stall, busy1, busy2, sb_full, err
  );

  modport slave (
    input  issue_fire, issue_we, issue_is_load, issue_dest,
    input  ld_done, ld_done_dest, retire, retire_dest,
    input  rs1, rs2, use1, use2, ds_valid,
    output stall, busy1, busy2, sb_full, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register counts of pending writes and outstanding loads,
// driving the decode load-use stall, forward-select flags and a sticky error.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  reg_scoreboard_if.slave sb
);
  localparam int               IDX_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pend_q [1:NREG-1];
  logic [CNT_W-1:0] pend_d [1:NREG-1];
  logic [CNT_W-1:0] ld_q   [1:NREG-1];
  logic [CNT_W-1:0] ld_d   [1:NREG-1];
  logic             err_q;
  logic             err_d;
  logic             iss_wr;

  // Net +1/-1 update; MSB of the result flags overflow or underflow.
  function automatic logic [CNT_W:0] step(input logic [CNT_W-1:0] c,
                                          input logic inc, input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == CNT_MAX) r[CNT_W] = 1'b1;
      else              r[CNT_W-1:0] = c + 1'b1;
    end else if (dec && !inc) begin
      if (c == '0) r[CNT_W] = 1'b1;
      else         r[CNT_W-1:0] = c - 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    iss_wr = sb.issue_fire && sb.issue_we && (sb.issue_dest != '0);
    pend_d = pend_q;
    ld_d   = ld_q;
    err_d  = err_q;
    for (int r = 1; r < NREG; r++) begin : upd
      logic [CNT_W:0] sp;
      logic [CNT_W:0] sl;
      sp = step(pend_q[r], iss_wr && (sb.issue_dest == IDX_W'(r)),
                sb.retire && (sb.retire_dest == IDX_W'(r)));
      sl = step(ld_q[r], iss_wr && sb.issue_is_load && (sb.issue_dest == IDX_W'(r)),
                sb.ld_done && (sb.ld_done_dest == IDX_W'(r)));
      pend_d[r] = sp[CNT_W-1:0];
      ld_d[r]   = sl[CNT_W-1:0];
      err_d     = err_d | sp[CNT_W] | sl[CNT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) begin
        pend_q[r] <= '0;
        ld_q[r]   <= '0;
      end
      err_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ld_q   <= ld_d;
      err_q  <= err_d;
    end
  end

  // Hazard outputs: registered counts qualified by this cycle's decode operands.
  logic [CNT_W-1:0] pend_rs1, pend_rs2, ld_rs1, ld_rs2, pend_dst;
  logic             ldh1, ldh2;

  always_comb begin
    pend_rs1   = (sb.rs1 == '0)        ? '0 : pend_q[sb.rs1];
    pend_rs2   = (sb.rs2 == '0)        ? '0 : pend_q[sb.rs2];
    ld_rs1     = (sb.rs1 == '0)        ? '0 : ld_q[sb.rs1];
    ld_rs2     = (sb.rs2 == '0)        ? '0 : ld_q[sb.rs2];
    pend_dst   = (sb.issue_dest == '0) ? '0 : pend_q[sb.issue_dest];
    sb.busy1   = sb.use1 && (sb.rs1 != '0) && (pend_rs1 != '0);
    sb.busy2   = sb.use2 && (sb.rs2 != '0) && (pend_rs2 != '0);
    ldh1       = sb.use1 && (sb.rs1 != '0) && (ld_rs1 != '0);
    ldh2       = sb.use2 && (sb.rs2 != '0) && (ld_rs2 != '0);
    sb.sb_full = sb.issue_we && (sb.issue_dest != '0) && (pend_dst == CNT_MAX);
    sb.stall   = sb.ds_valid && (ldh1 || ldh2 || sb.sb_full);
    sb.err     = err_q;
  end
endmodule
